ubus_arbiter: RTL and testbench
===============================

Name: ubus_arbiter

Overview:
- Parametrised UBUS bus controller and arbiter for N masters; owns the bus-phase sequencing (arbitration, address, data).
- Drives ubus_start, per-master grants, and no-op read/write encoding.
- Adds selectable fixed-priority or round-robin arbitration, a wait-state watchdog that aborts hung transfers, and owner/status outputs for scoreboards.
- Sits at the top of the UBUS environment as the single bus-control agent; replaces the two-master fixed arbiter.

Parameters:
- NUM_MASTERS, 2, number of requesting masters; legal range 1..16.
- ARB_MODE, 0, 0 = fixed priority (index 0 highest); 1 = round-robin.
- WAIT_TIMEOUT, 16, consecutive DATA-phase wait cycles before abort; 0 disables the watchdog; legal range 0..255.

Ports:
- ubus_clock  input  1  bus clock.
- ubus_reset  input  1  asynchronous, active-high reset.
- ubus_req  input  NUM_MASTERS  per-master bus request.
- ubus_gnt  output  NUM_MASTERS  per-master grant, one-hot or zero.
- ubus_start  output  1  arbitration-phase marker.
- ubus_read  output  1  driven 0 in no-op cycles, else 1'bz.
- ubus_write  output  1  driven 0 in no-op cycles, else 1'bz.
- ubus_bip  input  1  burst in progress.
- ubus_wait  input  1  slave wait.
- ubus_error  input  1  slave error.
- arb_owner  output  $clog2(NUM_MASTERS)+1  index of current owner; MSB set = no owner.
- arb_timeout  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset values: state = RST_EXIT, ubus_start = 0, ubus_gnt = 0, ubus_read/ubus_write = z, arb_owner = MSB set, arb_timeout = 0, wait counter = 0, round-robin pointer = NUM_MASTERS-1 (first search starts at master 0).
- State machine, rising edge:
  - RST_EXIT: start <= 1; next ARB.
  - ARB: start <= 0. If any ubus_gnt bit is set: next ADDR, arb_owner <= granted index. Otherwise next NOOP.
  - NOOP: start <= 1; next ARB.
  - ADDR: start <= 0; next DATA; wait counter cleared.
  - DATA, in priority order:
    - error = 1, or (bip = 0 and wait = 0): start <= 1; next ARB; arb_owner <= no owner.
    - WAIT_TIMEOUT != 0, wait = 1, and counter = WAIT_TIMEOUT-1: abort. start <= 1; next ARB; arb_timeout <= 1 for one cycle; owner cleared.
    - otherwise stay in DATA, start <= 0. Counter increments while wait = 1 and clears when wait = 0.
- Grants, falling edge:
  - If start = 1 and any req: exactly one gnt bit is set, chosen by the selector. Otherwise gnt <= 0.
  - Grant is therefore high for one full cycle, sampled by ARB on the next rising edge.
- Arbitration:
  - Fixed mode: lowest index requesting wins.
  - Round-robin mode: search starts at pointer+1 modulo NUM_MASTERS; the pointer updates to the winner at each grant.
  - NUM_MASTERS = 1 degenerates to a single-requester grant in both modes.
- No-op encoding, rising edge: if start = 1 and gnt = 0, read <= 0 and write <= 0; else both z.
- Error and timeout at the same edge: error takes precedence; arb_timeout stays 0.
- Req dropping after grant has no effect; the transfer proceeds.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous); the round-robin pointer is re-initialised.

Decomposition:
- Package ubus_arb_pkg holds:
  - state enum (RST_EXIT, ARB, NOOP, ADDR, DATA), with encodings 0, 3, 4, 1, 2 kept for waveform continuity;
  - ARB_FIXED / ARB_RR constants;
  - owner-width function.
- Sub-module ubus_arb_select: combinational rotating-priority selector. Inputs: req vector, base index, mode. Outputs: one-hot grant and index.

Test Plan:
- Reset release, no requests: start pulses every 2 cycles (RST_EXIT, then NOOP/ARB alternating); read = write = 0 in start cycles; gnt stays 0; owner MSB = 1.
- ARB_MODE = 0, NUM_MASTERS = 4, req = 4'b1010 held: every grant goes to master 1; arb_owner = 1; master 3 is never granted.
- ARB_MODE = 1, NUM_MASTERS = 4, req = 4'b1111 held, single-beat transfers: grant sequence 0, 1, 2, 3, 0.
- DATA with bip = 1 for 3 beats, then bip = 0 and wait = 0: DATA lasts 4 cycles; start asserts the cycle after the last beat.
- WAIT_TIMEOUT = 5, wait held 1 in DATA: abort at the 5th wait cycle; arb_timeout is high for exactly 1 cycle; start = 1; then re-arbitration.
- error = 1 at the same edge as the timeout boundary: normal end; arb_timeout = 0. Reset asserted in DATA: gnt = 0, start = 0, owner cleared, without waiting for a clock edge.

Source files
------------

// File: rtl/ubus_arb_pkg.sv
// Shared types and helpers for the UBUS bus controller/arbiter.
// State encodings are fixed so existing waveform setups keep decoding them.
package ubus_arb_pkg;

  typedef enum logic [2:0] {
    RST_EXIT = 3'd0,
    ADDR     = 3'd1,
    DATA     = 3'd2,
    ARB      = 3'd3,
    NOOP     = 3'd4
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Owner field carries the master index plus an MSB "no owner" flag.
  function automatic int owner_width(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ubus_arb_select.sv
// Rotating-priority request selector: picks the first requester at or after a start point.
// Purely combinational; zero latency, no flow control.
module ubus_arb_select
  import ubus_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  input  logic          mode,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int   first;
  int   cand;
  logic found;

  // Fixed mode always searches from 0; rotating mode starts just past the last winner.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    first = mode ? ((int'(base) + 1) % N) : 0;
    for (int i = 0; i < N; i++) begin
      cand = (first + i) % N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/ubus_arbiter.sv
// UBUS bus controller: sequences ARB/ADDR/DATA phases, grants one master per arbitration.
// Grants launch on the falling edge after start; a wait-state watchdog aborts hung DATA phases.
module ubus_arbiter
  import ubus_arb_pkg::*;
#(
  parameter int NUM_MASTERS  = 2,
  parameter int ARB_MODE     = ARB_FIXED,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic                         ubus_clock,
  input  logic                         ubus_reset,
  input  logic [NUM_MASTERS-1:0]       ubus_req,
  output logic [NUM_MASTERS-1:0]       ubus_gnt,
  output logic                         ubus_start,
  output logic                         ubus_read,
  output logic                         ubus_write,
  input  logic                         ubus_bip,
  input  logic                         ubus_wait,
  input  logic                         ubus_error,
  output logic [$clog2(NUM_MASTERS):0] arb_owner,
  output logic                         arb_timeout
);

  localparam int              OW       = owner_width(NUM_MASTERS);
  localparam int              IW       = idx_width(NUM_MASTERS);
  localparam logic [OW-1:0]   NO_OWNER = OW'(1) << (OW - 1);
  localparam logic [IW-1:0]   PTR_INIT = IW'(NUM_MASTERS - 1);
  localparam logic [7:0]      WT_LAST  = 8'((WAIT_TIMEOUT > 0) ? (WAIT_TIMEOUT - 1) : 0);
  localparam logic            WDOG_EN  = (WAIT_TIMEOUT != 0);

  arb_state_e      state_q, state_d;
  logic            start_q, start_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            timeout_q, timeout_d;
  logic            noop_q, noop_d;
  logic [7:0]      wcnt_q, wcnt_d;

  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] sel_gnt;
  logic [IW-1:0]          sel_idx;

  ubus_arb_select #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_select (
    .req  (ubus_req),
    .base (ptr_q),
    .mode (ARB_MODE == ARB_RR),
    .gnt  (sel_gnt),
    .idx  (sel_idx)
  );

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    wcnt_d    = wcnt_q;
    noop_d    = start_q && (gnt_q == '0);
    case (state_q)
      RST_EXIT: begin
        start_d = 1'b1;
        state_d = ARB;
      end
      ARB: begin
        start_d = 1'b0;
        if (|gnt_q) begin
          state_d = ADDR;
          owner_d = OW'(gidx_q);
        end else begin
          state_d = NOOP;
        end
      end
      NOOP: begin
        start_d = 1'b1;
        state_d = ARB;
      end
      ADDR: begin
        start_d = 1'b0;
        state_d = DATA;
        wcnt_d  = 8'd0;
      end
      DATA: begin
        // A slave error ends the transfer normally, even on the watchdog's final cycle.
        if (ubus_error || (!ubus_bip && !ubus_wait)) begin
          start_d = 1'b1;
          state_d = ARB;
          owner_d = NO_OWNER;
        end else if (WDOG_EN && ubus_wait && (wcnt_q == WT_LAST)) begin
          start_d   = 1'b1;
          state_d   = ARB;
          timeout_d = 1'b1;
          owner_d   = NO_OWNER;
        end else begin
          start_d = 1'b0;
          wcnt_d  = ubus_wait ? (wcnt_q + 8'd1) : 8'd0;
        end
      end
      default: begin
        start_d = 1'b0;
        state_d = RST_EXIT;
      end
    endcase
  end

  always_ff @(posedge ubus_clock or posedge ubus_reset) begin
    if (ubus_reset) begin
      state_q   <= RST_EXIT;
      start_q   <= 1'b0;
      owner_q   <= NO_OWNER;
      timeout_q <= 1'b0;
      noop_q    <= 1'b0;
      wcnt_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
      noop_q    <= noop_d;
      wcnt_q    <= wcnt_d;
    end
  end

  // Grant is launched mid-cycle so it is stable for the whole ARB sampling window.
  always_comb begin
    gnt_d  = '0;
    gidx_d = gidx_q;
    ptr_d  = ptr_q;
    if (start_q && (|ubus_req)) begin
      gnt_d  = sel_gnt;
      gidx_d = sel_idx;
      ptr_d  = sel_idx;
    end
  end

  always_ff @(negedge ubus_clock or posedge ubus_reset) begin
    if (ubus_reset) begin
      gnt_q  <= '0;
      gidx_q <= '0;
      ptr_q  <= PTR_INIT;
    end else begin
      gnt_q  <= gnt_d;
      gidx_q <= gidx_d;
      ptr_q  <= ptr_d;
    end
  end

  assign ubus_gnt    = gnt_q;
  assign ubus_start  = start_q;
  assign arb_owner   = owner_q;
  assign arb_timeout = timeout_q;
  assign ubus_read   = noop_q ? 1'b0 : 1'bz;
  assign ubus_write  = noop_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ubus_arbiter.sv
// Bench for ubus_arbiter: a fixed-priority and a round-robin instance share one stimulus stream
// and are compared against a phase-level reference model of the bus rules.
module tb_ubus_arbiter;

  localparam int N  = 4;
  localparam int WT = 5;
  localparam int PH_BOOT = 0, PH_ARB = 1, PH_IDLE = 2, PH_ADDR = 3, PH_DATA = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'd0;
  logic       bip = 1'b0, wt = 1'b0, err = 1'b0;

  wire [3:0] gnt_f, gnt_r;
  wire       start_f, start_r, rd_f, wr_f, rd_r, wr_r, to_f, to_r;
  wire [2:0] own_f, own_r;

  int n_cmp = 0;
  int n_err = 0;

  int m_phase, m_start, m_noop, m_to, m_cnt, m_gf, m_gr, m_of, m_or, m_ptr;

  always #5 clk = ~clk;

  ubus_arbiter #(.NUM_MASTERS(N), .ARB_MODE(0), .WAIT_TIMEOUT(WT)) u_fix (
    .ubus_clock(clk), .ubus_reset(rst), .ubus_req(req), .ubus_gnt(gnt_f),
    .ubus_start(start_f), .ubus_read(rd_f), .ubus_write(wr_f), .ubus_bip(bip),
    .ubus_wait(wt), .ubus_error(err), .arb_owner(own_f), .arb_timeout(to_f));

  ubus_arbiter #(.NUM_MASTERS(N), .ARB_MODE(1), .WAIT_TIMEOUT(WT)) u_rr (
    .ubus_clock(clk), .ubus_reset(rst), .ubus_req(req), .ubus_gnt(gnt_r),
    .ubus_start(start_r), .ubus_read(rd_r), .ubus_write(wr_r), .ubus_bip(bip),
    .ubus_wait(wt), .ubus_error(err), .arb_owner(own_r), .arb_timeout(to_r));

  function automatic int lowest(input logic [3:0] r);
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [3:0] gvec(input int g);
    logic [3:0] one;
    one = 4'd1;
    return (g < 0) ? 4'd0 : (one << g);
  endfunction

  function automatic logic [2:0] ovec(input int o);
    return (o < 0) ? 3'b100 : 3'(o);
  endfunction

  task automatic model_reset();
    m_phase = PH_BOOT; m_start = 0; m_noop = 0; m_to = 0; m_cnt = 0;
    m_gf = -1; m_gr = -1; m_of = -1; m_or = -1; m_ptr = N - 1;
  endtask

  task automatic model_rise();
    int nn;
    nn   = (m_start == 1 && m_gf < 0) ? 1 : 0;
    m_to = 0;
    case (m_phase)
      PH_BOOT, PH_IDLE: begin m_start = 1; m_phase = PH_ARB; end
      PH_ARB: begin
        m_start = 0;
        if (m_gf >= 0) begin m_phase = PH_ADDR; m_of = m_gf; m_or = m_gr; end
        else m_phase = PH_IDLE;
      end
      PH_ADDR: begin m_start = 0; m_phase = PH_DATA; m_cnt = 0; end
      default: begin
        if (err || (!bip && !wt)) begin
          m_start = 1; m_phase = PH_ARB; m_of = -1; m_or = -1;
        end else if (wt && m_cnt == WT - 1) begin
          m_start = 1; m_phase = PH_ARB; m_of = -1; m_or = -1; m_to = 1;
        end else begin
          m_start = 0;
          m_cnt = wt ? m_cnt + 1 : 0;
        end
      end
    endcase
    m_noop = nn;
  endtask

  task automatic model_fall();
    if (m_start == 1 && req != 4'd0) begin
      m_gf  = lowest(req);
      m_gr  = rr_pick(req, m_ptr);
      m_ptr = m_gr;
    end else begin
      m_gf = -1; m_gr = -1;
    end
  endtask

  // One full cycle; returns at falling edge + 1 with the model in step.
  task automatic tick();
    @(posedge clk); model_rise();
    @(negedge clk); model_fall();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'd0; bip = 1'b0; wt = 1'b0; err = 1'b0;
    model_reset();
    @(posedge clk); @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (gnt_f != 4'd0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (start_f !== 1'b0 || start_r !== 1'b0) begin n_err++; $display("FAIL rst_start got=%b/%b exp=0", start_f, start_r); end
    n_cmp++; if (gnt_f !== 4'd0 || gnt_r !== 4'd0) begin n_err++; $display("FAIL rst_gnt got=%b/%b exp=0000", gnt_f, gnt_r); end
    n_cmp++; if (own_f !== 3'b100 || own_r !== 3'b100) begin n_err++; $display("FAIL rst_owner got=%b/%b exp=100", own_f, own_r); end
    n_cmp++; if (to_f !== 1'b0 || to_r !== 1'b0) begin n_err++; $display("FAIL rst_timeout got=%b/%b exp=0", to_f, to_r); end
    model_reset();
    @(posedge clk); @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++; if (start_f !== 1'(k % 2)) begin n_err++; $display("FAIL idle_start k=%0d got=%b exp=%b", k, start_f, 1'(k % 2)); end
      n_cmp++; if (gnt_f !== 4'd0 || gnt_r !== 4'd0) begin n_err++; $display("FAIL idle_gnt k=%0d got=%b/%b exp=0000", k, gnt_f, gnt_r); end
      n_cmp++; if (own_f !== 3'b100) begin n_err++; $display("FAIL idle_owner k=%0d got=%b exp=100", k, own_f); end
      if (k % 2 == 0) begin
        n_cmp++; if (rd_f !== 1'b0 || wr_f !== 1'b0) begin n_err++; $display("FAIL idle_noop k=%0d got rd=%b wr=%b exp=0", k, rd_f, wr_f); end
      end
    end
  endtask

  task automatic test_fixed();
    int grants = 0;
    do_reset();
    req = 4'b1010;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (gnt_f != 4'd0) begin
        grants++;
        n_cmp++; if (gnt_f !== 4'b0010) begin n_err++; $display("FAIL fix_gnt got=%b exp=0010", gnt_f); end
      end
      if (own_f !== 3'b100) begin
        n_cmp++; if (own_f !== 3'd1) begin n_err++; $display("FAIL fix_owner got=%0d exp=1", own_f); end
      end
      n_cmp++; if (gnt_f[3] !== 1'b0) begin n_err++; $display("FAIL fix_m3 got=%b exp=0", gnt_f[3]); end
    end
    n_cmp++; if (grants < 3) begin n_err++; $display("FAIL fix_count got=%0d exp>=3", grants); end
  endtask

  task automatic test_rr();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int k = 0;
    logic [3:0] e;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 30 && k < 5; c++) begin
      tick();
      if (gnt_r != 4'd0) begin
        e = gvec(exp_seq[k]);
        n_cmp++; if (gnt_r !== e) begin n_err++; $display("FAIL rr_seq n=%0d got=%b exp=%b", k, gnt_r, e); end
        n_cmp++; if (gnt_f !== 4'b0001) begin n_err++; $display("FAIL rr_fixed_peer got=%b exp=0001", gnt_f); end
        k++;
      end
    end
    n_cmp++; if (k != 5) begin n_err++; $display("FAIL rr_budget got=%0d grants exp=5", k); end
  endtask

  task automatic test_burst();
    bit ok;
    do_reset();
    req = 4'b0001;
    wait_grant(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL burst_grant got=none exp=grant"); end
    req = 4'd0; bip = 1'b1;
    tick();
    n_cmp++; if (own_f !== 3'd0) begin n_err++; $display("FAIL burst_owner got=%b exp=000", own_f); end
    tick();
    for (int b = 0; b < 3; b++) begin
      tick();
      n_cmp++; if (start_f !== 1'b0 || own_f !== 3'd0) begin n_err++; $display("FAIL burst_beat b=%0d start=%b owner=%b exp 0/000", b, start_f, own_f); end
    end
    bip = 1'b0;
    tick();
    n_cmp++; if (start_f !== 1'b1 || own_f !== 3'b100) begin n_err++; $display("FAIL burst_end start=%b owner=%b exp 1/100", start_f, own_f); end
  endtask

  task automatic run_to_last_wait(input bit with_err);
    bit ok;
    do_reset();
    req = 4'b0001;
    wait_grant(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL wd_grant got=none exp=grant"); end
    req = 4'd0; wt = 1'b1;
    tick(); tick();
    for (int w = 0; w < 4; w++) begin
      tick();
      n_cmp++; if (to_f !== 1'b0 || start_f !== 1'b0) begin n_err++; $display("FAIL wd_early w=%0d to=%b start=%b exp 0/0", w, to_f, start_f); end
    end
    err = with_err;
    tick();
  endtask

  task automatic test_timeout();
    run_to_last_wait(1'b0);
    n_cmp++; if (to_f !== 1'b1 || to_r !== 1'b1) begin n_err++; $display("FAIL to_pulse got=%b/%b exp=1", to_f, to_r); end
    n_cmp++; if (start_f !== 1'b1 || own_f !== 3'b100) begin n_err++; $display("FAIL to_abort start=%b owner=%b exp 1/100", start_f, own_f); end
    wt = 1'b0;
    tick();
    n_cmp++; if (to_f !== 1'b0) begin n_err++; $display("FAIL to_width got=%b exp=0", to_f); end
  endtask

  task automatic test_error_vs_timeout();
    run_to_last_wait(1'b1);
    n_cmp++; if (to_f !== 1'b0 || to_r !== 1'b0) begin n_err++; $display("FAIL err_to got=%b/%b exp=0", to_f, to_r); end
    n_cmp++; if (start_f !== 1'b1 || own_f !== 3'b100) begin n_err++; $display("FAIL err_end start=%b owner=%b exp 1/100", start_f, own_f); end
    err = 1'b0; wt = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    req = 4'b0010;
    wait_grant(ok);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (gnt_f !== 4'd0 || start_f !== 1'b0) begin n_err++; $display("FAIL rmid_arb gnt=%b start=%b exp 0000/0", gnt_f, start_f); end
    model_reset();
    @(posedge clk); @(negedge clk); #1;
    rst = 1'b0;
    wait_grant(ok);
    req = 4'd0; bip = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (own_f !== 3'd1) begin n_err++; $display("FAIL rmid_pre owner=%b exp=001", own_f); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (own_f !== 3'b100 || own_r !== 3'b100) begin n_err++; $display("FAIL rmid_owner got=%b/%b exp=100", own_f, own_r); end
    n_cmp++; if (gnt_f !== 4'd0 || start_f !== 1'b0 || to_f !== 1'b0) begin n_err++; $display("FAIL rmid_outs gnt=%b start=%b to=%b exp 0", gnt_f, start_f, to_f); end
    bip = 1'b0;
    model_reset();
    @(posedge clk); @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(1, 15));
      bip = ($urandom_range(0, 3) == 0);
      wt  = wt ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 30);
      err = ($urandom_range(0, 39) == 0);
      tick();
      n_cmp++; if (start_f !== 1'(m_start) || start_r !== 1'(m_start)) begin n_err++; $display("FAIL rnd_start c=%0d got=%b/%b exp=%0d", c, start_f, start_r, m_start); end
      n_cmp++; if (gnt_f !== gvec(m_gf)) begin n_err++; $display("FAIL rnd_gnt_f c=%0d got=%b exp=%b", c, gnt_f, gvec(m_gf)); end
      n_cmp++; if (gnt_r !== gvec(m_gr)) begin n_err++; $display("FAIL rnd_gnt_r c=%0d got=%b exp=%b", c, gnt_r, gvec(m_gr)); end
      n_cmp++; if (own_f !== ovec(m_of)) begin n_err++; $display("FAIL rnd_own_f c=%0d got=%b exp=%b", c, own_f, ovec(m_of)); end
      n_cmp++; if (own_r !== ovec(m_or)) begin n_err++; $display("FAIL rnd_own_r c=%0d got=%b exp=%b", c, own_r, ovec(m_or)); end
      n_cmp++; if (to_f !== 1'(m_to) || to_r !== 1'(m_to)) begin n_err++; $display("FAIL rnd_timeout c=%0d got=%b/%b exp=%0d", c, to_f, to_r, m_to); end
      if (m_noop == 1) begin
        n_cmp++; if (rd_f !== 1'b0 || wr_f !== 1'b0 || rd_r !== 1'b0 || wr_r !== 1'b0) begin n_err++; $display("FAIL rnd_noop c=%0d rd=%b wr=%b exp=0", c, rd_f, wr_f); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_fixed();
    test_rr();
    test_burst();
    test_timeout();
    test_error_vs_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_budget got=no_finish exp=finish");
    $fatal(1, "simulation budget exhausted");
  end

endmodule
